scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// Address scan sequencer for a 4-to-16 decoder: steps a through 0..LAST_ADDR, dwelling on each.
// Define SCAN_SEQUENCER_BLANKING_EN to insert BLANK_CYCLES of sta=0 before every dwell.
module scan_sequencer #(
    parameter int unsigned LAST_ADDR    = 15,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    input  logic [7:0] dwell,
    output logic [3:0] a,
    output logic       sta,
    output logic       stb,
    output logic       stc,
    output logic       busy,
    output logic       frame_done
);

`ifdef SCAN_SEQUENCER_BLANKING_EN
    typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE, DWELL} state_t;
`endif

    localparam logic [3:0] LAST = LAST_ADDR[3:0];

    state_t     state_q;
    logic [3:0] a_q;
    logic [7:0] cnt_q;
    logic       sta_q, busy_q, fd_q, stop_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 4'd0;
            cnt_q       <= 8'd0;
            sta_q       <= 1'b0;
            busy_q      <= 1'b0;
            fd_q        <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        a_q    <= 4'd0;
                        busy_q <= 1'b1;
`ifdef SCAN_SEQUENCER_BLANKING_EN
                        state_q <= BLANK;
                        cnt_q   <= BLANK_LOAD;
                        sta_q   <= 1'b0;
`else
                        state_q <= DWELL;
                        cnt_q   <= dwell;
                        sta_q   <= 1'b1;
`endif
                    end
                end
`ifdef SCAN_SEQUENCER_BLANKING_EN
                BLANK: begin
                    if (stop) stop_pend_q <= 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_q <= DWELL;
                        cnt_q   <= dwell;
                        sta_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
`endif
                DWELL: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                        if (stop) stop_pend_q <= 1'b1;
                    end else begin
                        if (a_q == LAST) fd_q <= 1'b1;
                        // A stop arriving on the final dwell cycle still ends the scan here.
                        if (stop_pend_q || stop || (a_q == LAST && !continuous)) begin
                            state_q     <= IDLE;
                            sta_q       <= 1'b0;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                        end else begin
                            a_q <= (a_q == LAST) ? 4'd0 : a_q + 4'd1;
`ifdef SCAN_SEQUENCER_BLANKING_EN
                            state_q <= BLANK;
                            cnt_q   <= BLANK_LOAD;
                            sta_q   <= 1'b0;
`else
                            cnt_q   <= dwell;
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a          = a_q;
    assign sta        = sta_q;
    assign stb        = 1'b0;
    assign stc        = 1'b0;
    assign busy       = busy_q;
    assign frame_done = fd_q;

endmodule
